// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and defaults for the gcd scheduler
package gcd_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam int NREQ_DEF  = 4;
  localparam int NBITS_DEF = 32;

endpackage

// File: rtl/gcd_scheduler_rr_pick.sv
// rtl/gcd_scheduler_rr_pick.sv - combinational round-robin picker
// Searches last_id+1, last_id+2, ... modulo NREQ and returns the first set request.
module rr_pick import gcd_pkg::*; #(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic            any,
  output logic [IDW-1:0]  grant_id,
  output logic [NREQ-1:0] grant_oh
);

  logic [IDW-1:0] idx;

  always_comb begin
    any      = 1'b0;
    grant_id = '0;
    grant_oh = '0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_id) + k) % NREQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        grant_id = idx;
      end
    end
    grant_oh[grant_id] = any;
  end

endmodule

// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - shares one gcd engine among NREQ requesters
// Round-robin grant, operand capture, engine start/done sequencing, tagged response.
module gcd_scheduler import gcd_pkg::*; #(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int NBITS = NBITS_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] a_in,
  input  logic [NREQ*NBITS-1:0] b_in,
  output logic [NREQ-1:0]       ack,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [NBITS-1:0]      rsp_data,
  output logic                  busy,
  output logic                  gcd_start,
  output logic [NBITS-1:0]      gcd_a,
  output logic [NBITS-1:0]      gcd_b,
  input  logic [NBITS-1:0]      gcd_result,
  input  logic                  gcd_done
);

  sched_state_t     state_q;
  logic [IDW-1:0]   last_id_q, cur_id_q, rsp_id_q;
  logic [NBITS-1:0] gcd_a_q, gcd_b_q, rsp_data_q;
  logic             start_q, rsp_valid_q, busy_q;

  logic             any;
  logic [IDW-1:0]   grant_id;
  logic [NREQ-1:0]  grant_oh;
  logic [NBITS-1:0] a_slice [NREQ];
  logic [NBITS-1:0] b_slice [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_slice[g] = a_in[g*NBITS +: NBITS];
    assign b_slice[g] = b_in[g*NBITS +: NBITS];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .last_id  (last_id_q),
    .any      (any),
    .grant_id (grant_id),
    .grant_oh (grant_oh)
  );

  // Requests are only honoured while idle; ack is the picker's grant in that cycle.
  assign ack = (state_q == ARB) ? grant_oh : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      last_id_q   <= IDW'(NREQ-1);
      cur_id_q    <= '0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (any) begin
            gcd_a_q   <= a_slice[grant_id];
            gcd_b_q   <= b_slice[grant_id];
            cur_id_q  <= grant_id;
            last_id_q <= grant_id;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (gcd_done) begin
            rsp_data_q  <= gcd_result;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign gcd_start = start_q;
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb/tb_gcd_scheduler.sv - self-checking bench for gcd_scheduler
module tb_gcd_scheduler;
  localparam int NREQ  = 4;
  localparam int NBITS = 32;
  localparam int IDW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*NBITS-1:0] a_in, b_in;
  logic [NREQ-1:0] ack;
  logic rsp_valid, busy, gcd_start, gcd_done;
  logic [IDW-1:0] rsp_id;
  logic [NBITS-1:0] rsp_data, gcd_a, gcd_b, gcd_result;

  gcd_scheduler #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_result(gcd_result), .gcd_done(gcd_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NBITS-1:0] op_a [NREQ];
  logic [NBITS-1:0] op_b [NREQ];
  int want [NREQ];
  bit drop [NREQ];

  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*NBITS +: NBITS] = op_a[i];
      b_in[i*NBITS +: NBITS] = op_b[i];
    end
  end

  function automatic logic [NBITS-1:0] gcd_ref(logic [NBITS-1:0] a, logic [NBITS-1:0] b);
    logic [NBITS-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int rr_next(logic [NREQ-1:0] mask, int last);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Engine stand-in: random latency, garbage result except on done, optional stray dones.
  int eng_cnt;
  int eng_lat_lo = 1;
  int eng_lat_hi = 6;
  bit spurious_en = 1'b0;
  logic [NBITS-1:0] eng_a, eng_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_cnt <= 0;
      gcd_done <= 1'b0;
      gcd_result <= '0;
    end else begin
      gcd_done <= 1'b0;
      gcd_result <= $urandom;
      if (gcd_start) begin
        eng_cnt <= $urandom_range(eng_lat_hi, eng_lat_lo);
        eng_a <= gcd_a;
        eng_b <= gcd_b;
      end else if (eng_cnt == 1) begin
        gcd_done <= 1'b1;
        gcd_result <= gcd_ref(eng_a, eng_b);
        eng_cnt <= 0;
      end else if (eng_cnt > 1) begin
        eng_cnt <= eng_cnt - 1;
      end else if (spurious_en && $urandom_range(3, 0) == 0) begin
        gcd_done <= 1'b1;
      end
    end
  end

  typedef struct { int id; int cyc; logic [NBITS-1:0] a; logic [NBITS-1:0] b; logic [NREQ-1:0] mask; } ack_t;
  typedef struct { int id; logic [NBITS-1:0] data; int cyc; } rsp_t;
  ack_t ack_q[$];
  rsp_t rsp_q[$];
  int start_q[$];
  int done_q[$];
  bit busy_at[int];
  int bad_ack = 0;
  int cyc = 0;

  task automatic clear_logs();
    ack_q.delete(); rsp_q.delete(); start_q.delete(); done_q.delete(); busy_at.delete();
    bad_ack = 0;
  endtask

  task automatic step();
    ack_t e;
    rsp_t r;
    @(negedge clk);
    cyc++;
    busy_at[cyc] = busy;
    if (ack != '0 && (busy || $countones(ack) != 1)) bad_ack++;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        e.id = i; e.cyc = cyc; e.a = op_a[i]; e.b = op_b[i]; e.mask = req;
        ack_q.push_back(e);
        if (want[i] > 0) want[i]--;
        if (want[i] == 0) drop[i] = 1'b1;
      end
    end
    if (gcd_start) start_q.push_back(cyc);
    if (gcd_done) done_q.push_back(cyc);
    if (rsp_valid) begin
      r.id = int'(rsp_id); r.data = rsp_data; r.cyc = cyc;
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (drop[i]) begin req[i] = 1'b0; drop[i] = 1'b0; end
  endtask

  function automatic bit idle();
    bit ok = (req == '0) && !busy_at[cyc] && (ack_q.size() == rsp_q.size());
    for (int i = 0; i < NREQ; i++) if (want[i] != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic run_idle(input int budget, output bit timed_out);
    int n = 0;
    do begin step(); n++; end while (!idle() && n < budget);
    timed_out = !idle();
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin want[i] = 0; drop[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic raise(input int i, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input int n);
    op_a[i] = a; op_b[i] = b; want[i] = n; req[i] = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    @(negedge clk);
    checks++;
    if ({ack, rsp_valid, rsp_id, rsp_data, gcd_start, gcd_a, gcd_b, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", {ack, rsp_valid, rsp_id, rsp_data, gcd_start, gcd_a, gcd_b, busy});
    end
    @(posedge clk); #1; reset = 1'b0;
    clear_logs();
    repeat (3) step();
    checks++;
    if (ack_q.size() != 0 || start_q.size() != 0 || busy !== 1'b0 || gcd_a !== '0) begin
      errors++; $display("FAIL reset_idle acks %0d starts %0d busy %b expected 0 0 0", ack_q.size(), start_q.size(), busy);
    end
  endtask

  task automatic test_single_job();
    bit to;
    int rc;
    clear_logs();
    raise(2, 48, 18, 1);
    run_idle(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout got busy %b expected idle", busy); end
    checks++;
    if (ack_q.size() != 1 || ack_q[0].id != 2) begin
      errors++; $display("FAIL single_ack count %0d expected 1 on id 2", ack_q.size());
    end
    checks++;
    if (ack_q.size() != 1 || start_q.size() != 1 || start_q[0] != ack_q[0].cyc + 1) begin
      errors++; $display("FAIL single_start_latency starts %0d expected 1 one cycle after ack", start_q.size());
    end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0].id != 2 || rsp_q[0].data !== 32'd6) begin
      errors++; $display("FAIL single_rsp count %0d got %0d expected id 2 data 6", rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0].data : 0);
    end
    checks++;
    if (rsp_q.size() != 1 || done_q.size() != 1 || rsp_q[0].cyc != done_q[0] + 1) begin
      errors++; $display("FAIL single_rsp_latency rsps %0d dones %0d expected rsp 1 cycle after done", rsp_q.size(), done_q.size());
    end
    rc = (rsp_q.size() > 0) ? rsp_q[0].cyc : 0;
    checks++;
    if (busy_at[rc] !== 1'b1 || busy_at[rc+1] !== 1'b0) begin
      errors++; $display("FAIL single_busy_fall got %b%b expected 10", busy_at[rc], busy_at[rc+1]);
    end
  endtask

  task automatic test_contention();
    bit to;
    int exp_data [4] = '{4, 1, 25, 9};
    hold_reset();
    raise(0, 12, 8, 1); raise(1, 17, 5, 1); raise(2, 100, 75, 1); raise(3, 9, 9, 1);
    clear_logs();
    reset = 1'b0;
    run_idle(400, to);
    checks++;
    if (to || bad_ack != 0) begin errors++; $display("FAIL contention_sanity timeout %b bad_ack %0d expected 0 0", to, bad_ack); end
    for (int k = 0; k < 4; k++) begin
      int gid, rid;
      logic [NBITS-1:0] rd;
      gid = (k < ack_q.size()) ? ack_q[k].id : -1;
      rid = (k < rsp_q.size()) ? rsp_q[k].id : -1;
      rd = (k < rsp_q.size()) ? rsp_q[k].data : '1;
      checks++;
      if (gid != k || rid != k || rd !== exp_data[k]) begin
        errors++; $display("FAIL contention_job%0d ack %0d rsp %0d data %0d expected %0d %0d %0d", k, gid, rid, rd, k, k, exp_data[k]);
      end
    end
  endtask

  task automatic test_rotation();
    bit to;
    int exp_id [3] = '{1, 3, 0};
    clear_logs();
    raise(1, $urandom, $urandom_range(1000, 1), 1);
    run_idle(200, to);
    raise(0, $urandom_range(5000, 0) * 6, $urandom_range(5000, 0) * 6, 1);
    raise(3, $urandom, $urandom, 1);
    run_idle(400, to);
    checks++;
    if (to || ack_q.size() != 3 || rsp_q.size() != 3) begin
      errors++; $display("FAIL rotation_count acks %0d rsps %0d expected 3 3", ack_q.size(), rsp_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ack_q[k].id != exp_id[k] || rsp_q[k].id != exp_id[k] || rsp_q[k].data !== gcd_ref(ack_q[k].a, ack_q[k].b)) begin
          errors++; $display("FAIL rotation_job%0d ack %0d rsp %0d data %0d expected id %0d data %0d", k, ack_q[k].id, rsp_q[k].id, rsp_q[k].data, exp_id[k], gcd_ref(ack_q[k].a, ack_q[k].b));
        end
      end
    end
  endtask

  task automatic test_boundary();
    bit to;
    logic [NBITS-1:0] ta [4] = '{32'd0, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [NBITS-1:0] tb [4] = '{32'd7, 32'd0, 32'd0, 32'd1};
    logic [NBITS-1:0] te [4] = '{32'd7, 32'd7, 32'd0, 32'd1};
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      raise(k, ta[k], tb[k], 1);
      run_idle(200, to);
      checks++;
      if (to || rsp_q.size() != 1 || rsp_q[0].id != k || rsp_q[0].data !== te[k]) begin
        errors++; $display("FAIL boundary%0d rsps %0d data %0d expected id %0d data %0d", k, rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0].data : 0, k, te[k]);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    bit to, seen;
    int n;
    clear_logs();
    eng_lat_lo = 20; eng_lat_hi = 20;
    raise(2, 1000000, 3, 1);
    n = 0;
    while (start_q.size() == 0 && n < 50) begin step(); n++; end
    step();
    checks++;
    if (busy !== 1'b1 || gcd_a !== 32'd1000000) begin
      errors++; $display("FAIL midreset_pre busy %b gcd_a %0d expected 1 1000000", busy, gcd_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ack, rsp_valid, rsp_id, rsp_data, gcd_start, gcd_a, gcd_b, busy} !== '0) begin
      errors++; $display("FAIL midreset_async got %h expected 0", {ack, rsp_valid, rsp_id, rsp_data, gcd_start, gcd_a, gcd_b, busy});
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= rsp_valid; end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_rsp got 1 expected 0"); end
    @(posedge clk); #1;
    eng_lat_lo = 1; eng_lat_hi = 6;
    for (int i = 0; i < NREQ; i++) begin want[i] = 0; drop[i] = 1'b0; end
    req = '0;
    clear_logs();
    raise(1, 35, 14, 1);
    raise(3, $urandom, $urandom, 1);
    reset = 1'b0;
    run_idle(400, to);
    checks++;
    if (to || ack_q.size() != 2 || rsp_q.size() != 2 || ack_q[0].id != 1 || rsp_q[0].id != 1 || rsp_q[0].data !== 32'd7) begin
      errors++; $display("FAIL midreset_after acks %0d rsps %0d first_id %0d data %0d expected 2 2 1 7",
                         ack_q.size(), rsp_q.size(), (ack_q.size() > 0) ? ack_q[0].id : -1, (rsp_q.size() > 0) ? rsp_q[0].data : 0);
    end
  endtask

  task automatic test_withdraw_hold();
    bit to;
    int n, n3;
    clear_logs();
    eng_lat_lo = 5; eng_lat_hi = 5;
    raise(0, 84, 36, 2);
    n = 0;
    while (ack_q.size() == 0 && n < 50) begin step(); n++; end
    raise(3, 10, 4, 1);
    step(); step();
    req[3] = 1'b0; want[3] = 0;
    run_idle(400, to);
    eng_lat_lo = 1; eng_lat_hi = 6;
    n3 = 0;
    foreach (ack_q[k]) if (ack_q[k].id == 3) n3++;
    checks++;
    if (n3 != 0) begin errors++; $display("FAIL withdraw_no_ack3 got %0d expected 0", n3); end
    checks++;
    if (to || ack_q.size() != 2 || rsp_q.size() != 2 || ack_q[1].id != 0 || rsp_q[0].data !== 32'd12 || rsp_q[1].data !== 32'd12 || rsp_q[1].id != 0) begin
      errors++; $display("FAIL hold_two_jobs acks %0d rsps %0d expected 2 2 for id 0 data 12", ack_q.size(), rsp_q.size());
    end
    checks++;
    if (ack_q.size() == 2 && rsp_q.size() >= 1 && ack_q[1].cyc <= rsp_q[0].cyc) begin
      errors++; $display("FAIL hold_in_flight second ack cyc %0d expected after rsp cyc %0d", ack_q[1].cyc, rsp_q[0].cyc);
    end
  endtask

  task automatic test_random();
    bit to;
    int last, exp, nmin;
    logic [NBITS-1:0] g;
    hold_reset();
    clear_logs();
    reset = 1'b0;
    spurious_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && want[i] == 0 && $urandom_range(1, 0) == 1) begin
          g = $urandom_range(3000, 1);
          if ($urandom_range(3, 0) == 0) raise(i, $urandom, $urandom, $urandom_range(2, 1));
          else raise(i, g * $urandom_range(900, 0), g * $urandom_range(900, 0), $urandom_range(2, 1));
        end
      end
      repeat ($urandom_range(8, 1)) step();
      if ($urandom_range(4, 0) == 0) begin
        int w = $urandom_range(NREQ-1, 0);
        req[w] = 1'b0; want[w] = 0;
      end
    end
    run_idle(2000, to);
    spurious_en = 1'b0;
    checks++;
    if (to || bad_ack != 0 || ack_q.size() != rsp_q.size() || ack_q.size() < 10) begin
      errors++; $display("FAIL random_sanity timeout %b bad_ack %0d acks %0d rsps %0d expected 0 0 equal >=10", to, bad_ack, ack_q.size(), rsp_q.size());
    end
    nmin = (ack_q.size() < rsp_q.size()) ? ack_q.size() : rsp_q.size();
    last = NREQ - 1;
    for (int k = 0; k < nmin; k++) begin
      exp = rr_next(ack_q[k].mask, last);
      last = exp;
      checks++;
      if (ack_q[k].id != exp) begin
        errors++; $display("FAIL random_grant%0d got %0d expected %0d mask %b", k, ack_q[k].id, exp, ack_q[k].mask);
      end
      checks++;
      if (rsp_q[k].id != ack_q[k].id || rsp_q[k].data !== gcd_ref(ack_q[k].a, ack_q[k].b)) begin
        errors++; $display("FAIL random_rsp%0d got id %0d data %0d expected id %0d data %0d", k, rsp_q[k].id, rsp_q[k].data, ack_q[k].id, gcd_ref(ack_q[k].a, ack_q[k].b));
      end
      if (k + 1 < nmin) begin
        checks++;
        if (ack_q[k+1].cyc <= rsp_q[k].cyc) begin
          errors++; $display("FAIL random_in_flight%0d ack cyc %0d expected after %0d", k, ack_q[k+1].cyc, rsp_q[k].cyc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; want[i] = 0; drop[i] = 1'b0; end
    test_reset();
    test_single_job();
    test_contention();
    test_rotation();
    test_boundary();
    test_reset_mid_job();
    test_withdraw_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_scheduler.md
Name: gcd_scheduler

Overview:
- Shares one gcd engine (nbits-wide subtract/swap GCD core) among NREQ requesters.
- Round-robin arbitration; latches the winner's operands and sequences the engine's start/done handshake.
- Returns each result on a shared response bus, tagged with the requester ID.
- Sits between the client blocks and the single gcd instance at the same hierarchy level.

Parameters:
- NREQ, 4, number of requesters (2..16).
- NBITS, 32, operand/result width; must match the engine's nbits.
- IDW, $clog2(NREQ), width of requester ID (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request, level.
- a_in  in  NREQ*NBITS  packed operand A; slice i belongs to requester i.
- b_in  in  NREQ*NBITS  packed operand B; slice i belongs to requester i.
- ack  out  NREQ  one-hot, one-cycle pulse: request accepted, operands captured.
- rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_id valid.
- rsp_id  out  IDW  requester that owns rsp_data.
- rsp_data  out  NBITS  GCD result.
- busy  out  1  high whenever state != ARB.
- gcd_start  out  1  engine start pulse.
- gcd_a  out  NBITS  engine operand A.
- gcd_b  out  NBITS  engine operand B.
- gcd_result  in  NBITS  engine result.
- gcd_done  in  1  engine done pulse.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). The integrator drives the engine's reset_n from ~reset so both blocks share one reset domain.
- Reset values: ack=0, rsp_valid=0, rsp_id=0, rsp_data=0, gcd_start=0, gcd_a=0, gcd_b=0, busy=0. State resets to ARB. Priority pointer last_id resets to NREQ-1, so requester 0 wins first.
- FSM states and transitions:
  - ARB: if any req bit is set, the winner is the first set bit searching last_id+1, last_id+2, ... modulo NREQ. In that cycle: ack[winner]=1 (combinational). At the clock edge: capture a_in/b_in slices into gcd_a/gcd_b, store cur_id=winner, set last_id=winner, go to START. If no req bit is set, stay in ARB.
  - START: gcd_start=1 for exactly one cycle; go to WAIT.
  - WAIT: hold gcd_a/gcd_b. On gcd_done=1, register rsp_data<=gcd_result and rsp_id<=cur_id, then go to RESP.
  - RESP: rsp_valid=1 for one cycle; go to ARB.
- Latency: ack to gcd_start is 1 cycle. gcd_done to rsp_valid is 1 cycle. Minimum spacing between acks is engine latency + 3 cycles.
- rsp_data and rsp_id hold their value until the next RESP. gcd_a and gcd_b hold until the next capture.
- Requester rules:
  - Hold operands stable while req is high and until ack.
  - Dropping req before ack withdraws the request; no ack is issued.
  - req[i] still high in a later ARB cycle is treated as a new job, so requesters drop req the cycle after ack.
- Fairness: a requester that holds req is granted within NREQ jobs.
- Only one job is in flight at a time. req activity outside ARB is ignored; no ack is issued then.
- A gcd_done seen outside WAIT is ignored.
- Zero operands pass through unchanged; the engine defines the result (e.g. gcd(0,7)=7, gcd(0,0)=0).
- There is no timeout; the engine always terminates.
- Reset asserted mid-job aborts the job. No rsp_valid is issued for it. All outputs and the pointer return to their reset values immediately (asynchronous).

Decomposition:
- gcd_pkg holds:
  - enum sched_state_t {ARB, START, WAIT, RESP}, 2-bit.
  - localparam defaults NREQ_DEF=4, NBITS_DEF=32.
- Sub-module rr_pick: combinational round-robin picker.
  - Parameter NREQ.
  - Inputs: req, last_id.
  - Outputs: any, grant_id (IDW), grant_oh (NREQ).
- gcd_scheduler instantiates rr_pick, the FSM and the capture/response registers. It does not instantiate the engine; integration does.

Test Plan:
- Single job: req[2] with a=48, b=18 -> ack[2] for 1 cycle, gcd_start 1 cycle later, then rsp_valid with rsp_id=2, rsp_data=6; busy falls the cycle after RESP.
- Contention: req[0..3] all high from reset, each requester dropping req after its ack -> acks in order 0,1,2,3; responses in the same order with the correct GCDs (e.g. (12,8)=4, (17,5)=1, (100,75)=25, (9,9)=9).
- Rotation: after requester 1 is served, req[0] and req[3] rise together -> requester 3 is granted first, then 0.
- Boundary operands: (0,7) -> 7; (7,0) -> 7; (0,0) -> 0; (2^32-1, 1) -> 1, each with the correct rsp_id.
- Reset mid-job: assert reset during WAIT for (1000000,3) -> all outputs 0 asynchronously and no rsp_valid. After release, req[1] (35,14) -> requester 1 acked first, rsp_data=7.
- Withdrawal/hold: req[3] dropped before ack -> no ack[3]. req[0] held across two ARB visits -> two acks and two responses.
